// File: rtl/nas_pkg.sv
// Shared constants for the nibble add sequencer: FSM encoding, nibble width,
// and the index-width helper used to size the nibble counter.
package nas_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NIBBLE_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single-nibble build still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry adder, purely combinational.
// Latency: none. Backpressure: none (no handshake).
// Bit-level carry chain; carry-in enters bit 0, carry-out leaves bit 3.
module nibble_adder
  import nas_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_add_sequencer.sv
// Multi-cycle WIDTH-bit adder time-sharing one nibble adder, LSB nibble first.
// Latency: result valid NIB+1 cycles after the accept cycle; no overlap between ops.
// Backpressure: in_ready low while busy; result held in DONE until out_ready. Macro: NAS_ADD_SUB_EN.
module nibble_add_sequencer
  import nas_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_w(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  logic [1:0]          state;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [WIDTH-1:0]    sum_r;
  logic                carry_r;
  logic                cout_r;
  logic [IW-1:0]       idx;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] b_in;
  logic [NIBBLE_W-1:0] s_nib;
  logic                co_nib;
  logic                carry_init;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_r[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_r[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

`ifdef NAS_ADD_SUB_EN
  logic sub_r;

  // Subtract as a + ~b + 1: invert b per nibble and seed the carry with ~cin.
  assign b_in       = sub_r ? ~b_nib : b_nib;
  assign carry_init = sub ? ~cin : cin;

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_r <= 1'b0;
    end else if (state == ST_IDLE && in_valid) begin
      sub_r <= sub;
    end
  end
`else
  logic unused_sub;

  assign unused_sub = sub;
  assign b_in       = b_nib;
  assign carry_init = cin;
`endif

  nibble_adder u_nibble_adder (
    .a  (a_nib),
    .b  (b_in),
    .ci (carry_r),
    .s  (s_nib),
    .co (co_nib)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= carry_init;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) sum_r[i*NIBBLE_W +: NIBBLE_W] <= s_nib;
          end
          carry_r <= co_nib;
          idx     <= idx + 1'b1;
          if (idx == LAST) begin
            cout_r <= co_nib;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE) && !reset;
  assign out_valid = (state == ST_DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule
